uart_rx_fsm: RTL and testbench

UART_RX_FSM -- requirements
Module: uart_rx_fsm

---
 rtl/uart_rx_pkg.sv | 26 ++
 rtl/uart_rx_fsm_if.sv | 26 ++
 rtl/uart_rx_sampler.sv | 66 ++++++
 rtl/uart_rx_fsm.sv | 125 ++++++++++++
 tb/tb_uart_rx_fsm.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART receiver: state encoding, data width and the
// positions of the three mid-bit samples relative to PRESCALE/2.
package uart_rx_pkg;

  localparam int unsigned DATA_WIDTH    = 8;
  localparam int unsigned BitCntWidth   = $clog2(DATA_WIDTH);
  localparam int unsigned PrescaleWidth = 6;

  // Plain constants rather than an enum so the encoding matches older blocks.
  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;

  // Samples are taken at PRESCALE/2 - SampleLead, PRESCALE/2 and PRESCALE/2 + SampleLag.
  localparam int unsigned SampleLead = 1;
  localparam int unsigned SampleLag  = 1;
  // The voted bit is usable this many clocks after PRESCALE/2.
  localparam int unsigned VoteDelay  = 2;

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_fsm_if.sv
// Receiver bus: serial input and configuration in, received byte and status out.
interface uart_rx_fsm_if;
  import uart_rx_pkg::*;

  logic                     RX_IN;
  logic [PrescaleWidth-1:0] PRESCALE;
  logic                     PAR_EN;
  logic                     PAR_TYP;
  logic [DATA_WIDTH-1:0]    P_DATA;
  logic                     DATA_VALID;
  logic                     PAR_ERR;
  logic                     STP_ERR;

  // Driver of the serial line and configuration.
  modport master (
    output RX_IN, PRESCALE, PAR_EN, PAR_TYP,
    input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR
  );

  // The receiver itself.
  modport slave (
    input  RX_IN, PRESCALE, PAR_EN, PAR_TYP,
    output P_DATA, DATA_VALID, PAR_ERR, STP_ERR
  );

endinterface

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and 3-sample majority vote around the bit midpoint.
module uart_rx_sampler
  import uart_rx_pkg::*;
(
  input  logic                     CLK_FSM,
  input  logic                     RST_FSM,
  input  logic                     run,
  input  logic                     rx,
  input  logic [PrescaleWidth-1:0] prescale,
  output logic                     bit_end,
  output logic                     vote_ready,
  output logic                     majority
);

  logic [PrescaleWidth-1:0] edge_cnt_q;
  logic [PrescaleWidth-1:0] edge_cnt_d;
  logic [PrescaleWidth-1:0] half;
  logic [PrescaleWidth-1:0] pos_first;
  logic [PrescaleWidth-1:0] pos_mid;
  logic [PrescaleWidth-1:0] pos_last;
  logic [PrescaleWidth-1:0] pos_vote;
  logic [PrescaleWidth-1:0] last_edge;
  logic [2:0]               samples_q;

  // Sample and strobe positions derived from the current prescale.
  always_comb begin
    half       = prescale >> 1;
    pos_first  = half - PrescaleWidth'(SampleLead);
    pos_mid    = half;
    pos_last   = half + PrescaleWidth'(SampleLag);
    pos_vote   = half + PrescaleWidth'(VoteDelay);
    last_edge  = prescale - PrescaleWidth'(1);
    bit_end    = (edge_cnt_q == last_edge);
    vote_ready = (edge_cnt_q == pos_vote);
    majority   = majority3(samples_q);
  end

  // Edge counter: held at zero while idle, wraps on every bit boundary.
  always_comb begin
    edge_cnt_d = edge_cnt_q + PrescaleWidth'(1);
    if (!run || bit_end) begin
      edge_cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge CLK_FSM or negedge RST_FSM) begin
    if (!RST_FSM) begin
      edge_cnt_q <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
    end
  end

  // Capture the three mid-bit samples; each bit period overwrites them.
  always_ff @(posedge CLK_FSM or negedge RST_FSM) begin
    if (!RST_FSM) begin
      samples_q <= '0;
    end else if (run) begin
      if (edge_cnt_q == pos_first) samples_q[0] <= rx;
      if (edge_cnt_q == pos_mid)   samples_q[1] <= rx;
      if (edge_cnt_q == pos_last)  samples_q[2] <= rx;
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver: frame FSM, LSB-first shift register, parity check and
// registered byte/status outputs. Bit timing comes from uart_rx_sampler.
module uart_rx_fsm
  import uart_rx_pkg::*;
(
  input  logic         CLK_FSM,
  input  logic         RST_FSM,
  uart_rx_fsm_if.slave bus
);

  logic [2:0]             state_q, state_d;
  logic [BitCntWidth-1:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic                   par_pend_q, par_pend_d;
  logic [DATA_WIDTH-1:0]  p_data_q, p_data_d;
  logic                   data_valid_q, data_valid_d;
  logic                   par_err_q, par_err_d;
  logic                   stp_err_q, stp_err_d;

  logic run;
  logic bit_end;
  logic vote_ready;
  logic majority;
  logic expected_par;

  assign run          = (state_q != StIdle);
  assign expected_par = (^shift_q) ^ bus.PAR_TYP;

  uart_rx_sampler u_sampler (
    .CLK_FSM    (CLK_FSM),
    .RST_FSM    (RST_FSM),
    .run        (run),
    .rx         (bus.RX_IN),
    .prescale   (bus.PRESCALE),
    .bit_end    (bit_end),
    .vote_ready (vote_ready),
    .majority   (majority)
  );

  // Frame sequencing and next values of all registered state.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_pend_d   = par_pend_q;
    p_data_d     = p_data_q;
    data_valid_d = 1'b0;
    par_err_d    = par_err_q;
    stp_err_d    = stp_err_q;
    case (state_q)
      StIdle: begin
        if (!bus.RX_IN) begin
          state_d    = StStart;
          bit_cnt_d  = '0;
          par_pend_d = 1'b0;
          par_err_d  = 1'b0;
          stp_err_d  = 1'b0;
        end
      end
      StStart: begin
        // A start bit that votes high was a glitch.
        if (bit_end) begin
          state_d = majority ? StIdle : StData;
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d   = {majority, shift_q[DATA_WIDTH-1:1]};
          bit_cnt_d = bit_cnt_q + BitCntWidth'(1);
          if (bit_cnt_q == BitCntWidth'(DATA_WIDTH - 1)) begin
            state_d = bus.PAR_EN ? StParity : StStop;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          par_pend_d = (majority != expected_par);
          state_d    = StStop;
        end
      end
      StStop: begin
        // Decide right after the vote so a new start edge late in the stop bit is caught.
        if (vote_ready) begin
          state_d   = StIdle;
          par_err_d = par_pend_q;
          stp_err_d = !majority;
          if (!par_pend_q && majority) begin
            p_data_d     = shift_q;
            data_valid_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK_FSM or negedge RST_FSM) begin
    if (!RST_FSM) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_pend_q   <= 1'b0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_pend_q   <= par_pend_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
    end
  end

  assign bus.P_DATA     = p_data_q;
  assign bus.DATA_VALID = data_valid_q;
  assign bus.PAR_ERR    = par_err_q;
  assign bus.STP_ERR    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: fixed frame table, hand-written corner sequences and
// random frames checked against a frame-level model of the receiver.
module tb_uart_rx_fsm;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_fsm_if bus ();

  uart_rx_fsm dut (
    .CLK_FSM (clk),
    .RST_FSM (rst_n),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Every cycle DATA_VALID is high, record the byte presented with it.
  logic [7:0] seen[$];
  always @(negedge clk) begin
    if (bus.DATA_VALID === 1'b1) seen.push_back(bus.P_DATA);
  end

  typedef struct {
    int         p;
    bit         pe;
    bit         pt;
    logic [7:0] data;
    bit         par_bit;
    bit         stop_bit;
    int         exp_pulses;
    logic [7:0] exp_pdata;
    bit         exp_perr;
    bit         exp_serr;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_frame(input string tag, input int pulses, input logic [7:0] pdata,
                             input bit perr, input bit serr);
    check({tag, " pulses"}, seen.size(), pulses);
    check({tag, " P_DATA"}, bus.P_DATA, pdata);
    check({tag, " PAR_ERR"}, bus.PAR_ERR, perr);
    check({tag, " STP_ERR"}, bus.STP_ERR, serr);
  endtask

  // Hold a line level for len clocks, optionally inverting one clock (glitch_at).
  task automatic drive_bit(input logic level, input int len, input int glitch_at);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      bus.RX_IN = (i == glitch_at) ? ~level : level;
    end
  endtask

  // Single-clock glitch on one of the three mid-bit sample clocks, or none.
  function automatic int pick_glitch(input int p, input bit glitchy);
    if (glitchy && ($urandom_range(0, 3) == 0)) return p / 2 + int'($urandom_range(0, 2));
    return -1;
  endfunction

  task automatic send_frame(input int p, input bit pe, input bit pt, input logic [7:0] data,
                            input bit par_bit, input bit stop_bit, input int stop_len,
                            input bit glitchy);
    bus.PRESCALE = 6'(p);
    bus.PAR_EN   = pe;
    bus.PAR_TYP  = pt;
    drive_bit(1'b0, p, -1);
    for (int b = 0; b < 8; b++) drive_bit(data[b], p, pick_glitch(p, glitchy));
    if (pe) drive_bit(par_bit, p, pick_glitch(p, glitchy));
    if (stop_bit) begin
      drive_bit(1'b1, stop_len, -1);
    end else begin
      // Low across the sample window only, then back to idle so no new frame starts.
      drive_bit(1'b0, p / 2 + 3, -1);
      drive_bit(1'b1, stop_len - (p / 2 + 3), -1);
    end
  endtask

  logic [7:0] model_pdata;

  initial begin
    int         p;
    bit         pe, pt, par_bit, stop_bit, exp_perr, exp_serr;
    logic [7:0] data;

    bus.RX_IN    = 1'b1;
    bus.PRESCALE = 6'd8;
    bus.PAR_EN   = 1'b0;
    bus.PAR_TYP  = 1'b0;

    vecs[0] = '{8,  1, 0, 8'hA5, 0, 1, 1, 8'hA5, 0, 0};
    vecs[1] = '{8,  0, 0, 8'h5E, 0, 1, 1, 8'h5E, 0, 0};
    vecs[2] = '{8,  1, 1, 8'hA5, 0, 1, 0, 8'h5E, 1, 0};
    vecs[3] = '{16, 0, 0, 8'h3C, 0, 0, 0, 8'h5E, 0, 1};
    vecs[4] = '{16, 0, 0, 8'hC3, 0, 1, 1, 8'hC3, 0, 0};

    // Reset values.
    repeat (3) @(negedge clk);
    check("reset DATA_VALID", bus.DATA_VALID, 0);
    check_frame("reset", 0, 8'h00, 0, 0);
    rst_n = 1'b1;
    drive_bit(1'b1, 4, -1);

    // Fixed frame table.
    for (int i = 0; i < 5; i++) begin
      seen.delete();
      send_frame(vecs[i].p, vecs[i].pe, vecs[i].pt, vecs[i].data, vecs[i].par_bit,
                 vecs[i].stop_bit, vecs[i].p, 1'b0);
      drive_bit(1'b1, 2, -1);
      check_frame($sformatf("table%0d", i), vecs[i].exp_pulses, vecs[i].exp_pdata,
                  vecs[i].exp_perr, vecs[i].exp_serr);
    end
    model_pdata = 8'hC3;

    // Short low pulse is rejected as a glitch; no output changes afterwards.
    seen.delete();
    bus.PRESCALE = 6'd16;
    bus.PAR_EN   = 1'b0;
    drive_bit(1'b0, 3, -1);
    drive_bit(1'b1, 12 * 16, -1);
    check_frame("glitch", 0, model_pdata, 0, 0);

    // Back-to-back frames: next start edge right after the stop-bit samples.
    seen.delete();
    send_frame(32, 0, 0, 8'h01, 0, 1, 32 / 2 + 3, 1'b0);
    send_frame(32, 0, 0, 8'h80, 0, 1, 32, 1'b0);
    drive_bit(1'b1, 2, -1);
    check("b2b pulses", seen.size(), 2);
    check("b2b first", (seen.size() > 0) ? seen[0] : 8'hxx, 8'h01);
    check("b2b second", (seen.size() > 1) ? seen[1] : 8'hxx, 8'h80);
    check("b2b P_DATA", bus.P_DATA, 8'h80);
    model_pdata = 8'h80;

    // Stop error so that status is non-zero before the reset test.
    seen.delete();
    send_frame(8, 0, 0, 8'h77, 0, 0, 8, 1'b0);
    drive_bit(1'b1, 2, -1);
    check_frame("stperr", 0, model_pdata, 0, 1);

    // Reset during data bit 4 aborts the frame.
    seen.delete();
    bus.PRESCALE = 6'd8;
    drive_bit(1'b0, 8, -1);
    for (int b = 0; b < 4; b++) drive_bit(bit'(b[0]), 8, -1);
    drive_bit(1'b1, 3, -1);
    @(negedge clk);
    rst_n     = 1'b0;
    bus.RX_IN = 1'b1;
    repeat (2) @(negedge clk);
    check("in-reset DATA_VALID", bus.DATA_VALID, 0);
    check_frame("in-reset", 0, 8'h00, 0, 0);
    rst_n = 1'b1;
    drive_bit(1'b1, 4 * 8, -1);
    check_frame("post-reset", 0, 8'h00, 0, 0);
    seen.delete();
    send_frame(8, 0, 0, 8'h5A, 0, 1, 8, 1'b0);
    drive_bit(1'b1, 2, -1);
    check_frame("after-reset", 1, 8'h5A, 0, 0);
    check("after-reset byte", (seen.size() > 0) ? seen[0] : 8'hxx, 8'h5A);
    model_pdata = 8'h5A;

    // Random frames with mid-bit single-clock glitches, checked against the model.
    for (int n = 0; n < 30; n++) begin
      p        = 8 << $urandom_range(0, 2);
      pe       = bit'($urandom_range(0, 1));
      pt       = bit'($urandom_range(0, 1));
      data     = 8'($urandom_range(0, 255));
      par_bit  = ((^data) ^ pt) ^ ($urandom_range(0, 3) == 0);
      stop_bit = ($urandom_range(0, 4) != 0);
      exp_perr = pe && (par_bit != ((^data) ^ pt));
      exp_serr = !stop_bit;
      seen.delete();
      send_frame(p, pe, pt, data, par_bit, stop_bit, p, 1'b1);
      drive_bit(1'b1, 2, -1);
      if (!exp_perr && !exp_serr) model_pdata = data;
      check_frame($sformatf("rand%0d p%0d pe%0d pt%0d d%02h", n, p, pe, pt, data),
                  (!exp_perr && !exp_serr) ? 1 : 0, model_pdata, exp_perr, exp_serr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
